// File: rtl/monster_pkg.sv
// Shared types and constants for the per-scanline monster scheduler.
package monster_pkg;

  localparam int CORDW      = 16;
  localparam int SPR_HEIGHT = 96;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2
  } sched_state_t;

  typedef logic signed [CORDW-1:0] coord_t;

endpackage

// File: rtl/monster_line_scheduler_free_slot_enc.sv
// Priority encoder: returns the lowest-index free sprite slot, if any.
module free_slot_enc #(
  parameter int N_SLOT = 2,
  parameter int SLW    = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
  input  logic [N_SLOT-1:0] free,
  output logic              found,
  output logic [SLW-1:0]    idx
);

  // Walk downward so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_SLOT - 1; k >= 0; k--) begin
      if (free[k]) begin
        found = 1'b1;
        idx   = SLW'(k);
      end
    end
  end

endmodule

// File: rtl/monster_line_scheduler.sv
// Per-scanline scheduler binding visible monsters to a small pool of sprite engines.
// Handshake: line is a single-cycle request accepted only in IDLE; slot_start is a single-cycle grant per engine; slot_done releases an engine only while IDLE.
module monster_line_scheduler
  import monster_pkg::*;
#(
  parameter int N_MON  = 8,
  parameter int N_SLOT = 2,
  parameter int IDW    = $clog2(N_MON)
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    replay,
  input  logic                    line,
  input  coord_t                  sy,
  input  logic [N_MON*CORDW-1:0]  mon_y,
  input  logic [N_MON-1:0]        mon_en,
  input  logic [N_SLOT-1:0]       slot_done,
  output logic [N_SLOT-1:0]       slot_start,
  output logic [N_SLOT*IDW-1:0]   slot_id,
  output logic [N_SLOT-1:0]       slot_busy,
  output logic                    ovf,
  output logic [7:0]              ovf_cnt,
  output logic                    late_err,
  output sched_state_t            state
);

  localparam int SLW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int HCW = $clog2(N_MON + 1);

  coord_t             sy_q;
  logic [IDW-1:0]     i;
  logic [HCW-1:0]     hits;
  logic [N_SLOT-1:0]  pend;
  logic [IDW-1:0]     id_q [N_SLOT];

  coord_t                 cur_y;
  logic signed [CORDW:0]  sy_ext, top_ext, bot_ext;
  logic                   hit, bind_hit, last, ovf_next, free_found;
  logic [SLW-1:0]         free_idx;
  logic [HCW-1:0]         hits_next;
  logic [N_SLOT-1:0]      pend_next;

  free_slot_enc #(.N_SLOT(N_SLOT), .SLW(SLW)) u_free_slot_enc (
    .free  (~slot_busy),
    .found (free_found),
    .idx   (free_idx)
  );

  // Span test is widened by one bit so a sprite near the coordinate limit cannot wrap.
  always_comb begin
    cur_y     = mon_y[int'(i)*CORDW +: CORDW];
    sy_ext    = {sy_q[CORDW-1], sy_q};
    top_ext   = {cur_y[CORDW-1], cur_y};
    bot_ext   = top_ext + (CORDW+1)'(SPR_HEIGHT);
    hit       = mon_en[i] && (sy_ext >= top_ext) && (sy_ext < bot_ext);
    bind_hit  = hit && free_found;
    last      = (i == IDW'(N_MON - 1));
    hits_next = hits;
    if (hit && (hits != HCW'(N_MON))) hits_next = hits + 1'b1;
    pend_next = pend;
    if (bind_hit) pend_next[free_idx] = 1'b1;
    ovf_next  = int'(hits_next) > N_SLOT;
  end

  for (genvar g = 0; g < N_SLOT; g++) begin : g_id
    assign slot_id[g*IDW +: IDW] = id_q[g];
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      sy_q       <= '0;
      i          <= '0;
      hits       <= '0;
      pend       <= '0;
      slot_start <= '0;
      slot_busy  <= '0;
      ovf        <= 1'b0;
      ovf_cnt    <= '0;
      late_err   <= 1'b0;
      for (int k = 0; k < N_SLOT; k++) id_q[k] <= '0;
    end else if (replay) begin
      state      <= IDLE;
      sy_q       <= '0;
      i          <= '0;
      hits       <= '0;
      pend       <= '0;
      slot_start <= '0;
      slot_busy  <= '0;
      ovf        <= 1'b0;
      ovf_cnt    <= '0;
      late_err   <= 1'b0;
      for (int k = 0; k < N_SLOT; k++) id_q[k] <= '0;
    end else begin
      slot_start <= '0;
      case (state)
        IDLE: begin
          if (line) begin
            sy_q      <= sy;
            slot_busy <= '0;
            hits      <= '0;
            pend      <= '0;
            i         <= '0;
            state     <= SCAN;
          end else begin
            slot_busy <= slot_busy & ~slot_done;
          end
        end
        SCAN: begin
          if (line) late_err <= 1'b1;
          hits <= hits_next;
          pend <= pend_next;
          if (bind_hit) begin
            id_q[free_idx]      <= i;
            slot_busy[free_idx] <= 1'b1;
          end
          // Start pulse is loaded here so it is visible during the ISSUE cycle.
          if (last) begin
            slot_start <= pend_next;
            ovf        <= ovf_next;
            if (ovf_next && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
            state      <= ISSUE;
          end else begin
            i <= i + 1'b1;
          end
        end
        ISSUE: begin
          if (line) late_err <= 1'b1;
          pend  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_monster_line_scheduler.sv
// Self-checking bench for monster_line_scheduler against a list-based scanline model.
module tb_monster_line_scheduler;
  import monster_pkg::*;

  localparam int N_MON  = 8;
  localparam int N_SLOT = 2;
  localparam int IDW    = 3;

  logic                   clk;
  logic                   i_rst_n;
  logic                   replay;
  logic                   line;
  coord_t                 sy;
  logic [N_MON*CORDW-1:0] mon_y;
  logic [N_MON-1:0]       mon_en;
  logic [N_SLOT-1:0]      slot_done;
  logic [N_SLOT-1:0]      slot_start;
  logic [N_SLOT*IDW-1:0]  slot_id;
  logic [N_SLOT-1:0]      slot_busy;
  logic                   ovf;
  logic [7:0]             ovf_cnt;
  logic                   late_err;
  sched_state_t           state;

  coord_t my [N_MON];

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  int                    exp_id [N_SLOT];
  int                    exp_cnt;
  logic                  exp_late;
  logic [N_SLOT-1:0]     exp_start;
  logic [N_SLOT*IDW-1:0] exp_id_bus;
  logic                  exp_ovf;

  // observations captured by run_line
  logic                  obs_early;
  logic [N_SLOT-1:0]     obs_start;
  logic [N_SLOT*IDW-1:0] obs_id;
  logic [N_SLOT-1:0]     obs_busy;
  logic                  obs_ovf;
  logic [7:0]            obs_cnt;
  logic [N_SLOT-1:0]     obs_after;

  monster_line_scheduler #(.N_MON(N_MON), .N_SLOT(N_SLOT)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .replay     (replay),
    .line       (line),
    .sy         (sy),
    .mon_y      (mon_y),
    .mon_en     (mon_en),
    .slot_done  (slot_done),
    .slot_start (slot_start),
    .slot_id    (slot_id),
    .slot_busy  (slot_busy),
    .ovf        (ovf),
    .ovf_cnt    (ovf_cnt),
    .late_err   (late_err),
    .state      (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N_MON; k++) mon_y[k*CORDW +: CORDW] = my[k];
  end

  task automatic do_reset();
    i_rst_n = 1'b0;
    replay = 1'b0; line = 1'b0; sy = '0; slot_done = '0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N_SLOT; k++) exp_id[k] = 0;
    exp_cnt = 0;
    exp_late = 1'b0;
  endtask

  // ---------------- model ----------------
  // Collect visible monsters in index order; the first N_SLOT take slots 0.. in order.
  task automatic predict(input int s);
    int hit_q[$];
    hit_q = {};
    for (int m = 0; m < N_MON; m++) begin
      int y;
      y = int'(my[m]);
      if (mon_en[m] && s >= y && s < y + SPR_HEIGHT) hit_q.push_back(m);
    end
    exp_start = '0;
    for (int k = 0; k < N_SLOT && k < hit_q.size(); k++) begin
      exp_start[k] = 1'b1;
      exp_id[k] = hit_q[k];
    end
    exp_ovf = hit_q.size() > N_SLOT;
    if (exp_ovf && exp_cnt < 255) exp_cnt++;
    for (int k = 0; k < N_SLOT; k++) exp_id_bus[k*IDW +: IDW] = exp_id[k][IDW-1:0];
  endtask

  // ---------------- driver ----------------
  // Line pulse in cycle 0; observe cycles 1..10. Optional extra line in cycle 3, slot_done in cycle 4.
  task automatic run_line(input int s, input bit late_pulse, input logic [N_SLOT-1:0] done_scan);
    line = 1'b1;
    sy = coord_t'(s);
    @(negedge clk);
    line = 1'b0;
    obs_early = 1'b0;
    for (int k = 1; k <= N_MON; k++) begin
      if (slot_start !== '0) obs_early = 1'b1;
      line = (k == 3) && late_pulse;
      sy = (k == 3) ? coord_t'(s + 37) : coord_t'(s);
      slot_done = (k == 4) ? done_scan : '0;
      @(negedge clk);
    end
    line = 1'b0;
    slot_done = '0;
    obs_start = slot_start;
    obs_id    = slot_id;
    obs_busy  = slot_busy;
    obs_ovf   = ovf;
    obs_cnt   = ovf_cnt;
    @(negedge clk);
    obs_after = slot_start;
  endtask

  task automatic set_table(input logic [N_MON-1:0] en, input int y0);
    mon_en = en;
    for (int k = 0; k < N_MON; k++) my[k] = coord_t'(y0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_table('0, 0);
    do_reset();
    total_cnt++;
    if ({slot_start, slot_id, slot_busy, ovf, ovf_cnt, late_err} !== '0)
      $display("FAIL reset_outputs: got start=%b id=%h busy=%b ovf=%b cnt=%0d late=%b, want all 0",
               slot_start, slot_id, slot_busy, ovf, ovf_cnt, late_err);
    else pass_cnt++;
    total_cnt++;
    if (state !== IDLE) $display("FAIL reset_state: got %0d want %0d", state, IDLE);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    set_table(8'h05, 0);
    my[0] = 16'sd100;
    my[2] = 16'sd150;
    predict(160);
    run_line(160, 1'b0, '0);
    total_cnt++;
    if (obs_early !== 1'b0) $display("FAIL basic_early: start seen before cycle 9");
    else pass_cnt++;
    total_cnt++;
    if (obs_start !== 2'b11) $display("FAIL basic_start: got %b want 11", obs_start);
    else pass_cnt++;
    total_cnt++;
    if (obs_id !== {3'd2, 3'd0}) $display("FAIL basic_id: got %h want %h", obs_id, {3'd2, 3'd0});
    else pass_cnt++;
    total_cnt++;
    if (obs_ovf !== 1'b0 || obs_busy !== 2'b11) $display("FAIL basic_ovf_busy: got ovf=%b busy=%b want 0/11", obs_ovf, obs_busy);
    else pass_cnt++;
    total_cnt++;
    if (obs_after !== '0) $display("FAIL basic_pulse_width: got %b in cycle 10 want 00", obs_after);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    set_table(8'h0F, 0);
    predict(10);
    run_line(10, 1'b0, '0);
    total_cnt++;
    if (obs_id !== {3'd1, 3'd0} || obs_start !== 2'b11)
      $display("FAIL ovf_bind: got id=%h start=%b want id=%h start=11", obs_id, obs_start, {3'd1, 3'd0});
    else pass_cnt++;
    total_cnt++;
    if (obs_ovf !== 1'b1 || obs_cnt !== 8'd1) $display("FAIL ovf_flag: got ovf=%b cnt=%0d want 1/1", obs_ovf, obs_cnt);
    else pass_cnt++;
  endtask

  task automatic test_span_edges();
    int sys [4] = '{195, 196, 99, 10};
    int tops [4] = '{100, 100, 100, -50};
    logic [1:0] want [4] = '{2'b01, 2'b00, 2'b00, 2'b01};
    for (int t = 0; t < 4; t++) begin
      set_table(8'h01, 0);
      my[0] = coord_t'(tops[t]);
      predict(sys[t]);
      run_line(sys[t], 1'b0, '0);
      total_cnt++;
      if (obs_start !== want[t] || obs_start !== exp_start)
        $display("FAIL span_edge sy=%0d top=%0d: got start=%b want %b", sys[t], tops[t], obs_start, want[t]);
      else pass_cnt++;
    end
  endtask

  task automatic test_late_line();
    set_table(8'h06, 0);
    my[1] = 16'sd40;
    my[2] = 16'sd60;
    predict(100);
    exp_late = 1'b1;
    run_line(100, 1'b1, '0);
    total_cnt++;
    if (late_err !== exp_late) $display("FAIL late_err: got %b want 1", late_err);
    else pass_cnt++;
    total_cnt++;
    if (obs_early !== 1'b0 || obs_start !== exp_start || obs_id !== exp_id_bus)
      $display("FAIL late_timing: got early=%b start=%b id=%h want 0/%b/%h", obs_early, obs_start, obs_id, exp_start, exp_id_bus);
    else pass_cnt++;
  endtask

  task automatic test_slot_done();
    set_table(8'h03, 0);
    predict(20);
    run_line(20, 1'b0, 2'b11);
    total_cnt++;
    if (obs_busy !== 2'b11) $display("FAIL done_in_scan: got busy=%b want 11", obs_busy);
    else pass_cnt++;
    slot_done = 2'b01;
    @(negedge clk);
    slot_done = '0;
    total_cnt++;
    if (slot_busy !== 2'b10) $display("FAIL done_in_idle: got busy=%b want 10", slot_busy);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int s;
      s = int'($urandom_range(0, 350)) - 50;
      mon_en = N_MON'($urandom);
      for (int k = 0; k < N_MON; k++) my[k] = coord_t'(s - 120 + int'($urandom_range(0, 140)));
      predict(s);
      run_line(s, 1'b0, '0);
      total_cnt++;
      if ({obs_early, obs_start, obs_id, obs_busy, obs_ovf, obs_cnt} !== {1'b0, exp_start, exp_id_bus, exp_start, exp_ovf, 8'(exp_cnt)})
        $display("FAIL random_line %0d sy=%0d en=%b: got start=%b id=%h busy=%b ovf=%b cnt=%0d want %b/%h/%b/%b/%0d",
                 n, s, mon_en, obs_start, obs_id, obs_busy, obs_ovf, obs_cnt, exp_start, exp_id_bus, exp_start, exp_ovf, exp_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_replay();
    logic seen;
    set_table(8'h0F, 0);
    line = 1'b1;
    sy = 16'sd10;
    @(negedge clk);
    line = 1'b0;
    repeat (3) @(negedge clk);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    for (int k = 0; k < N_SLOT; k++) exp_id[k] = 0;
    exp_cnt = 0;
    exp_late = 1'b0;
    total_cnt++;
    if ({slot_start, slot_id, slot_busy, ovf, ovf_cnt, late_err} !== '0 || state !== IDLE)
      $display("FAIL replay_clear: got start=%b id=%h busy=%b ovf=%b cnt=%0d late=%b state=%0d want all 0",
               slot_start, slot_id, slot_busy, ovf, ovf_cnt, late_err, state);
    else pass_cnt++;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (slot_start !== '0) seen = 1'b1;
      @(negedge clk);
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL replay_no_start: got a start pulse want none");
    else pass_cnt++;
  endtask

  task automatic test_ovf_saturation();
    set_table(8'h07, 0);
    for (int n = 1; n <= 300; n++) begin
      predict(10);
      run_line(10, 1'b0, '0);
      if (n == 255) begin
        total_cnt++;
        if (obs_cnt !== 8'd255) $display("FAIL ovf_reach_255: got %0d want 255", obs_cnt);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (obs_cnt !== 8'(exp_cnt) || obs_cnt !== 8'd255 || obs_ovf !== 1'b1)
      $display("FAIL ovf_saturate: got cnt=%0d ovf=%b want 255/1", obs_cnt, obs_ovf);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_span_edges();
    test_late_line();
    test_slot_done();
    test_random();
    test_replay();
    test_ovf_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
